tx_rr_arbiter: RTL and testbench
================================

// Module: tx_rr_arbiter
// PURPOSE
//  Round-robin req/ack scheduler sharing the single PCIe AXIS TX path among N
//  TLP sources. Grants one requester at a time, holds grant for whole packets
//  by snooping the muxed AXIS handshake, and enforces one idle cycle between
//  grants. A stall watchdog force-releases a grant whose owner stops sending.
//  Sits ahead of the TX mux; ack[] drives the mux select and requester acks.
// PARAMETERS
//  N          4       number of requesters (2..8)
//  IDX_W      2       width of grant_idx; must equal clog2(N)
//  TIMEOUT    1024    stall cycles before forced release; 0 disables watchdog
//  TMO_W      16      width of stall counter; TIMEOUT < 2**TMO_W
// PORTS
//  clk          in   1      core clock
//  sys_rst      in   1      asynchronous reset, active-high
//  req          in   N      per-source request, held high for whole transfer
//  ack          out  N      one-hot grant (all-zero when idle)
//  grant_idx    out  IDX_W  index of current/last owner
//  busy         out  1      any ack high
//  tx_tvalid    in   1      muxed s_axis_tx_tvalid (snooped)
//  tx_tready    in   1      s_axis_tx_tready from core (snooped)
//  tx_tlast     in   1      muxed s_axis_tx_tlast (snooped)
//  timeout_err  out  1      one-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset (async assert, sync release): ack=0, grant_idx=N-1, busy=0,
//   timeout_err=0, in_pkt=0, stall counter=0, state=IDLE.
//  beat = tx_tvalid & tx_tready. in_pkt set on beat&~tx_tlast, cleared on
//   beat&tx_tlast; counted only in GRANT.
//  States: IDLE, GRANT, GAP. All outputs registered.
//  IDLE: if any req, pick first set req searching grant_idx+1, +2, ... mod N
//   (wrap N-1 -> 0); next cycle ack[sel]=1, grant_idx=sel, -> GRANT.
//   Latency req->ack = 1 cycle. No req: stay IDLE, grant_idx unchanged.
//  GRANT: release when req[grant_idx]=0 and in_pkt=0 and no beat this cycle
//   with ~tx_tlast -> ack=0 next cycle, -> GAP. req dropped mid-packet: ack
//   held until the tlast beat is accepted, release the cycle after it.
//   Requests from other sources ignored while in GRANT (no preemption).
//  Watchdog (TIMEOUT>0): counter clears on entry to GRANT and on every beat;
//   increments on cycles in GRANT without a beat. Reaching TIMEOUT: ack=0,
//   timeout_err=1 for one cycle, in_pkt cleared, -> GAP, regardless of req.
//   Counter saturates; never wraps.
//  GAP: exactly one cycle with ack=0, then IDLE (arbitration re-evaluated
//   there, so a source that keeps req high after release is served again only
//   after all other pending sources, or immediately if it is the only one).
//  Simultaneous: req rise on several sources same cycle -> RR order decides.
//   Beat with tlast in the same cycle req drops -> normal release.
//  ack is always one-hot or zero; owner's req low in IDLE is never granted.
//  sys_rst mid-packet: all acks drop immediately (async); no framing repair.
// TESTING
//  1 Reset, req=4'b0001 -> ack=0001 one cycle later, grant_idx=0, busy=1.
//  2 req=4'b1111 held, each source sends 1-beat packet then drops req for one
//    cycle -> grant order 0,1,2,3,0 with one ack=0 cycle between grants.
//  3 Owner 2 drops req after beat 1 of a 4-beat packet -> ack[2] stays high
//    until tlast beat accepted, drops next cycle; GAP then next source.
//  4 tx_tready=0 for 3 beats mid-packet (TIMEOUT=8) -> no release, packet
//    completes; counter never reaches 8.
//  5 TIMEOUT=8, owner holds req with tvalid=0 -> ack drops after 8 stall
//    cycles, timeout_err pulses once, next pending source granted after GAP.
//  6 Assert sys_rst while ack=0100 mid-packet -> ack=0 asynchronously,
//    grant_idx=N-1; after release req=4'b0001 -> source 0 granted.

Source files
------------

// File: rtl/tx_rr_arbiter.sv
// tx_rr_arbiter
// Round-robin scheduler for the shared PCIe AXIS TX path. One source owns the
// path at a time and keeps it for whole packets, which the arbiter tracks by
// watching the muxed AXIS handshake. There is always one cycle with no owner
// between two grants. A stall watchdog takes the path back from an owner that
// stops sending. ack[] drives the TX mux select and the per-source acks.

module tx_rr_arbiter #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 16
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  input  logic             tx_tvalid,
  input  logic             tx_tready,
  input  logic             tx_tlast,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
  localparam logic [N-1:0]     ONE_HOT = {{(N-1){1'b0}}, 1'b1};
  localparam bit               WD_EN   = (TIMEOUT > 0);

  state_t           state;
  logic [1:0]       rst_pipe;
  logic             rst;
  logic             in_pkt;
  logic [TMO_W-1:0] stall_cnt;
  logic [TMO_W-1:0] stall_inc;
  logic             beat;
  logic             pkt_open;
  logic             release_ok;
  logic             wd_fire;
  logic             any_req;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;

  // Reset asserts at once from sys_rst, but releases only after two clean
  // clock edges so every register leaves reset on the same edge.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst = rst_pipe[1];

  // A beat is an accepted transfer on the shared TX path. pkt_open says the
  // owner will still be in the middle of a packet after this cycle, taking a
  // beat that happens right now into account, so a tlast beat in the same
  // cycle as the request drop releases straight away.
  assign beat       = tx_tvalid & tx_tready;
  assign pkt_open   = (in_pkt & ~(beat & tx_tlast)) | (beat & ~tx_tlast);
  assign release_ok = ~req[grant_idx] & ~pkt_open;
  assign stall_inc  = stall_cnt + TMO_W'(1);
  assign wd_fire    = WD_EN & ~beat & (stall_inc == TMO_LIM);

  // Round-robin pick: search upward from the source after the last owner.
  // The loop runs from farthest to nearest so the nearest requester wins.
  always_comb begin
    any_req = |req;
    sel     = grant_idx;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(grant_idx) + i) % N);
      if (req[cand]) begin
        sel = cand;
      end
    end
  end

  // Arbitration FSM. All outputs are registered here. GAP is the one cycle
  // with no owner after a release; the pick made during it uses the updated
  // grant_idx, so the source just released goes to the back of the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ack         <= '0;
      grant_idx   <= IDX_W'(N - 1);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      in_pkt      <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            ack       <= ONE_HOT << sel;
            grant_idx <= sel;
            busy      <= 1'b1;
            in_pkt    <= 1'b0;
            stall_cnt <= '0;
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (beat) begin
            in_pkt    <= ~tx_tlast;
            stall_cnt <= '0;
          end else if (stall_cnt != TMO_MAX) begin
            stall_cnt <= stall_inc;
          end
          if (wd_fire) begin
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            in_pkt      <= 1'b0;
            state       <= GAP;
          end else if (release_ok) begin
            ack   <= '0;
            busy  <= 1'b0;
            state <= GAP;
          end
        end
        default: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// tb_tx_rr_arbiter
// Directed bench for tx_rr_arbiter with a short watchdog (TIMEOUT=8).
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so each sample shows the result of the edge just passed.

module tb_tx_rr_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             sys_rst;
  logic [N-1:0]     req;
  logic [N-1:0]     ack;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             tx_tvalid;
  logic             tx_tready;
  logic             tx_tlast;
  logic             timeout_err;

  int total_checks;
  int passed_checks;

  tx_rr_arbiter #(
    .N       (N),
    .IDX_W   (IDX_W),
    .TIMEOUT (8),
    .TMO_W   (16)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .ack         (ack),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .tx_tvalid   (tx_tvalid),
    .tx_tready   (tx_tready),
    .tx_tlast    (tx_tlast),
    .timeout_err (timeout_err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request vector and the snooped AXIS handshake.
  task automatic apply_stimulus(input logic [N-1:0] r, input logic v,
                                input logic rdy, input logic last);
    req       = r;
    tx_tvalid = v;
    tx_tready = rdy;
    tx_tlast  = last;
  endtask

  // One comparison against a hand-computed value.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) begin
      passed_checks++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check ack, grant_idx and busy together.
  task automatic check_grant(input string tag, input logic [N-1:0] exp_ack,
                             input logic [IDX_W-1:0] exp_idx);
    check_output({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check_output({tag, "_idx"}, 32'(grant_idx), 32'(exp_idx));
    check_output({tag, "_busy"}, 32'(busy), 32'(exp_ack != '0));
  endtask

  // Pulse reset and wait out the release synchroniser with no requests.
  task automatic do_reset();
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  logic [N-1:0]     order_ack [5];
  logic [IDX_W-1:0] order_idx [5];

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    order_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    order_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    sys_rst = 1'b1;
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    #2;
    check_grant("rst", 4'b0000, 2'd3);
    check_output("rst_tmo", 32'(timeout_err), 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_grant("rst_idle", 4'b0000, 2'd3);

    // 1: single request, granted one cycle later
    apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t1_grant", 4'b0001, 2'd0);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    check_grant("t1_release", 4'b0000, 2'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t1_idle", 4'b0000, 2'd0);

    // 2: all four requesting, one-beat packets, strict rotation 0,1,2,3,0
    do_reset();
    apply_stimulus(4'b1111, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t2_g0", order_ack[0], order_idx[0]);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(4'b1111 & ~order_ack[k], 1'b1, 1'b1, 1'b1);
      tick();
      check_output($sformatf("t2_gap%0d", k), 32'(ack), 32'd0);
      apply_stimulus(4'b1111, 1'b0, 1'b1, 1'b0);
      tick();
      check_grant($sformatf("t2_g%0d", k + 1), order_ack[k + 1],
                  order_idx[k + 1]);
    end
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    check_output("t2_end", 32'(ack), 32'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();

    // 3: owner 2 drops req after beat 1 of a 4-beat packet
    apply_stimulus(4'b0100, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t3_grant", 4'b0100, 2'd2);
    apply_stimulus(4'b0100, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("t3_b1", 32'(ack), 32'h4);
    apply_stimulus(4'b1000, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("t3_b2", 32'(ack), 32'h4);
    apply_stimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    tick();
    check_output("t3_pause", 32'(ack), 32'h4);
    apply_stimulus(4'b1000, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("t3_b3", 32'(ack), 32'h4);
    apply_stimulus(4'b1000, 1'b1, 1'b1, 1'b1);
    tick();
    check_grant("t3_release", 4'b0000, 2'd2);
    apply_stimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t3_next", 4'b1000, 2'd3);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    check_output("t3_end", 32'(ack), 32'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();

    // 4: backpressure mid-packet must not trigger the watchdog; a beat
    //    between two stalls clears the count (3 + 7 stalls would exceed 8)
    apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t4_grant", 4'b0001, 2'd0);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    apply_stimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_output("t4_stall3_ack", 32'(ack), 32'h1);
    check_output("t4_stall3_tmo", 32'(timeout_err), 32'd0);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    apply_stimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("t4_stall7_tmo%0d", i), 32'(timeout_err), 32'd0);
    end
    check_output("t4_stall7_ack", 32'(ack), 32'h1);
    apply_stimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    check_grant("t4_release", 4'b0000, 2'd0);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();

    // 5: owner 1 holds req but never sends; source 3 waiting
    apply_stimulus(4'b0010, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t5_grant", 4'b0010, 2'd1);
    apply_stimulus(4'b1010, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("t5_hold%0d", i), 32'(ack), 32'h2);
    end
    check_output("t5_hold_tmo", 32'(timeout_err), 32'd0);
    tick();
    check_grant("t5_fire", 4'b0000, 2'd1);
    check_output("t5_tmo_pulse", 32'(timeout_err), 32'd1);
    tick();
    check_grant("t5_next", 4'b1000, 2'd3);
    check_output("t5_tmo_clear", 32'(timeout_err), 32'd0);

    // 6: reset while source 2 is mid-packet
    apply_stimulus(4'b0100, 1'b1, 1'b1, 1'b1);
    tick();
    check_output("t6_rel3", 32'(ack), 32'd0);
    apply_stimulus(4'b0100, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t6_grant2", 4'b0100, 2'd2);
    apply_stimulus(4'b0100, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    sys_rst = 1'b1;
    #1;
    check_grant("t6_async", 4'b0000, 2'd3);
    apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_grant("t6_post_rst", 4'b0000, 2'd3);
    apply_stimulus(4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    check_grant("t6_grant0", 4'b0001, 2'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
